// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Contents: controller state enum, default register-address width,
// and the hardwired zero-register index.
package pipe_ctrl_pkg;

   typedef enum logic {
      RUN      = 1'b0,
      MEM_WAIT = 1'b1
   } haz_state_t;

   localparam int unsigned REG_AW_DEFAULT = 5;
   localparam int unsigned REG_ZERO       = 0;

endpackage

// File: rtl/haz_wait_timer.sv
// Memory-wait timer for the hazard controller.
// Ports:
//   clk, reset  - clock, asynchronous active-high reset
//   start       - load 1 (first cycle of a new wait)
//   clear       - return to 0 (wait finished)
//   inc         - advance by one wait cycle
//   expired     - count has reached MEM_TIMEOUT
module haz_wait_timer #(
   parameter int unsigned MEM_TIMEOUT = 64
) (
   input  logic clk,
   input  logic reset,
   input  logic start,
   input  logic clear,
   input  logic inc,
   output logic expired
);

   localparam int unsigned CW = $clog2(MEM_TIMEOUT + 1);

   logic [CW-1:0] count;

   // start wins over clear; both win over inc
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (start) begin
         count <= CW'(1);
      end else if (clear) begin
         count <= '0;
      end else if (inc) begin
         count <= count + CW'(1);
      end
   end

   assign expired = (count == CW'(MEM_TIMEOUT));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline.
// Resolves load-use hazards, branch/jump redirects and data-memory waits,
// abandoning a hung memory access after MEM_TIMEOUT wait cycles.
// Optional feature macro: HAZ_PERF_EN (stall/flush performance counters;
// when undefined the counter ports are tied to 0).
// Ports:
//   clk, reset                  - clock, asynchronous active-high reset
//   id_rs/id_rt, id_uses_rs/rt  - source operands of the ID instruction
//   ex_mem_read, ex_write_reg   - load in EX and its destination
//   ex_branch_taken, id_jump    - control-flow redirects
//   mem_req, mem_ready          - data-memory handshake from MEM
//   pc_en .. memwb_flush        - pipeline register enables/flushes
//   mem_err                     - one-cycle pulse on memory timeout
//   stall_cycles, flush_events  - performance counters
module pipe_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned REG_AW      = REG_AW_DEFAULT,
   parameter int unsigned MEM_TIMEOUT = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic              id_uses_rs,
   input  logic              id_uses_rt,
   input  logic              ex_mem_read,
   input  logic [REG_AW-1:0] ex_write_reg,
   input  logic              ex_branch_taken,
   input  logic              id_jump,
   input  logic              mem_req,
   input  logic              mem_ready,
   output logic              pc_en,
   output logic              ifid_en,
   output logic              ifid_flush,
   output logic              idex_en,
   output logic              idex_flush,
   output logic              exmem_en,
   output logic              memwb_flush,
   output logic              mem_err,
   output logic [31:0]       stall_cycles,
   output logic [31:0]       flush_events
);

   haz_state_t state, next_state;

   logic mem_pending;
   logic load_use;
   logic advance;
   logic drop;
   logic tmr_start;
   logic tmr_clear;
   logic tmr_inc;
   logic tmr_expired;

   // A dropped request (mem_req low) counts as completed.
   assign mem_pending = mem_req && !mem_ready;

   assign load_use = ex_mem_read
                  && (ex_write_reg != REG_AW'(REG_ZERO))
                  && ((id_uses_rs && (id_rs == ex_write_reg))
                   || (id_uses_rt && (id_rt == ex_write_reg)));

   haz_wait_timer #(
      .MEM_TIMEOUT (MEM_TIMEOUT)
   ) u_wait_timer (
      .clk     (clk),
      .reset   (reset),
      .start   (tmr_start),
      .clear   (tmr_clear),
      .inc     (tmr_inc),
      .expired (tmr_expired)
   );

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= RUN;
      end else begin
         state <= next_state;
      end
   end

   // Next-state and pipeline control
   always_comb begin
      next_state  = state;
      advance     = 1'b1;
      drop        = 1'b0;
      tmr_start   = 1'b0;
      tmr_clear   = 1'b0;
      tmr_inc     = 1'b0;
      pc_en       = 1'b1;
      ifid_en     = 1'b1;
      ifid_flush  = 1'b0;
      idex_en     = 1'b1;
      idex_flush  = 1'b0;
      exmem_en    = 1'b1;
      memwb_flush = 1'b0;
      mem_err     = 1'b0;

      case (state)
         RUN: begin
            if (mem_pending) begin
               advance    = 1'b0;
               next_state = MEM_WAIT;
               tmr_start  = 1'b1;
            end
         end
         MEM_WAIT: begin
            if (!mem_pending) begin
               next_state = RUN;
               tmr_clear  = 1'b1;
            end else if (tmr_expired) begin
               // Give up on the access: advance, but bubble MEM/WB
               drop       = 1'b1;
               next_state = RUN;
               tmr_clear  = 1'b1;
            end else begin
               advance = 1'b0;
               tmr_inc = 1'b1;
            end
         end
         default: begin
            next_state = RUN;
         end
      endcase

      if (reset) begin
         pc_en       = 1'b0;
         ifid_en     = 1'b0;
         ifid_flush  = 1'b1;
         idex_en     = 1'b0;
         idex_flush  = 1'b1;
         exmem_en    = 1'b0;
         memwb_flush = 1'b1;
      end else if (!advance) begin
         // Freeze everything upstream of MEM; branch/load-use wait in place
         pc_en       = 1'b0;
         ifid_en     = 1'b0;
         idex_en     = 1'b0;
         exmem_en    = 1'b0;
         memwb_flush = 1'b1;
      end else begin
         if (ex_branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
         end else if (load_use) begin
            // Hold PC and IF/ID (a pending jump stays in ID), insert a bubble
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
         end else if (id_jump) begin
            ifid_flush = 1'b1;
         end
         memwb_flush = drop;
         mem_err     = drop;
      end
   end

`ifdef HAZ_PERF_EN
   // Performance counters, wrapping modulo 2^32
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cycles <= '0;
         flush_events <= '0;
      end else begin
         if (!pc_en) begin
            stall_cycles <= stall_cycles + 32'd1;
         end
         if (ifid_flush || idex_flush) begin
            flush_events <= flush_events + 32'd1;
         end
      end
   end
`else
   assign stall_cycles = '0;
   assign flush_events = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a
// pending-age reference model.
module tb_pipe_hazard_ctrl;

   localparam int unsigned AW = 5;
   localparam int          TO = 4;

   // Output vector order: pc_en ifid_en ifid_flush idex_en idex_flush exmem_en memwb_flush mem_err
   localparam logic [7:0] V_RESET   = 8'b0010_1010;
   localparam logic [7:0] V_FREEZE  = 8'b0000_0010;
   localparam logic [7:0] V_NORMAL  = 8'b1101_0100;
   localparam logic [7:0] V_LOADUSE = 8'b0001_1100;
   localparam logic [7:0] V_BRANCH  = 8'b1111_1100;
   localparam logic [7:0] V_JUMP    = 8'b1111_0100;
   localparam logic [7:0] V_TIMEOUT = 8'b1101_0111;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [AW-1:0] id_rs = '0;
   logic [AW-1:0] id_rt = '0;
   logic          id_uses_rs = 1'b0;
   logic          id_uses_rt = 1'b0;
   logic          ex_mem_read = 1'b0;
   logic [AW-1:0] ex_write_reg = '0;
   logic          ex_branch_taken = 1'b0;
   logic          id_jump = 1'b0;
   logic          mem_req = 1'b0;
   logic          mem_ready = 1'b0;
   logic          pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
   logic          exmem_en, memwb_flush, mem_err;
   logic [31:0]   stall_cycles, flush_events;
   logic [7:0]    dut_out;

   int            n_checks = 0;
   int            n_fail = 0;
   int            pend = 0;
   logic [31:0]   exp_stall = '0;
   logic [31:0]   exp_flush = '0;

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(
      .REG_AW      (AW),
      .MEM_TIMEOUT (TO)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .id_rs           (id_rs),
      .id_rt           (id_rt),
      .id_uses_rs      (id_uses_rs),
      .id_uses_rt      (id_uses_rt),
      .ex_mem_read     (ex_mem_read),
      .ex_write_reg    (ex_write_reg),
      .ex_branch_taken (ex_branch_taken),
      .id_jump         (id_jump),
      .mem_req         (mem_req),
      .mem_ready       (mem_ready),
      .pc_en           (pc_en),
      .ifid_en         (ifid_en),
      .ifid_flush      (ifid_flush),
      .idex_en         (idex_en),
      .idex_flush      (idex_flush),
      .exmem_en        (exmem_en),
      .memwb_flush     (memwb_flush),
      .mem_err         (mem_err),
      .stall_cycles    (stall_cycles),
      .flush_events    (flush_events)
   );

   assign dut_out = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
                     exmem_en, memwb_flush, mem_err};

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   // Reference: p = number of consecutive cycles already spent frozen on
   // the current outstanding access (0 when none is outstanding).
   function automatic logic [7:0] model_out(input int p);
      logic       pending;
      logic       lu;
      logic [7:0] o;
      if (reset) return V_RESET;
      pending = mem_req && !mem_ready;
      if (pending && p < TO) return V_FREEZE;
      lu = ex_mem_read && (ex_write_reg != 0)
        && ((id_uses_rs && id_rs == ex_write_reg) || (id_uses_rt && id_rt == ex_write_reg));
      if (ex_branch_taken)  o = V_BRANCH;
      else if (lu)          o = V_LOADUSE;
      else if (id_jump)     o = V_JUMP;
      else                  o = V_NORMAL;
      o[1] = pending;
      o[0] = pending;
      return o;
   endfunction

   // Per-cycle comparison against the model
   always @(negedge clk) begin : cmp
      logic [7:0] e;
      if (reset) begin
         pend      = 0;
         exp_stall = '0;
         exp_flush = '0;
      end
      e = model_out(pend);
      chk("model_outputs", 32'(dut_out), 32'(e));
`ifdef HAZ_PERF_EN
      chk("stall_cycles", stall_cycles, exp_stall);
      chk("flush_events", flush_events, exp_flush);
`else
      chk("stall_cycles_tied", stall_cycles, 32'd0);
      chk("flush_events_tied", flush_events, 32'd0);
`endif
      if (!reset) begin
         if (!e[7]) exp_stall = exp_stall + 32'd1;
         if (e[5] || e[3]) exp_flush = exp_flush + 32'd1;
         if (mem_req && !mem_ready) pend = (pend >= TO) ? 0 : pend + 1;
         else pend = 0;
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_in();
      id_rs = '0; id_rt = '0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
      ex_mem_read = 1'b0; ex_write_reg = '0; ex_branch_taken = 1'b0;
      id_jump = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
   endtask

   task automatic rst_pulse();
      cyc();
      reset = 1'b1;
      clr_in();
      cyc();
      reset = 1'b0;
   endtask

   initial begin : stim
      int stuck;
      #1;
      chk("reset_values", 32'(dut_out), 32'(V_RESET));
      cyc();
      cyc();
      reset = 1'b0;
      #1 chk("idle_run", 32'(dut_out), 32'(V_NORMAL));

      // Load-use on rs, then the bubble clears it
      rst_pulse();
      ex_mem_read = 1'b1; ex_write_reg = AW'(8); id_uses_rs = 1'b1; id_rs = AW'(8);
      #1 chk("load_use", 32'(dut_out), 32'(V_LOADUSE));
      cyc();
      ex_mem_read = 1'b0;
      #1 chk("load_use_release", 32'(dut_out), 32'(V_NORMAL));

      // Load into $0 never stalls
      cyc();
      ex_mem_read = 1'b1; ex_write_reg = '0; id_rs = '0;
      #1 chk("load_use_r0", 32'(dut_out), 32'(V_NORMAL));

      // Match on rt; unused operand does not match
      cyc();
      clr_in();
      ex_mem_read = 1'b1; ex_write_reg = AW'(3); id_uses_rt = 1'b1; id_rt = AW'(3);
      #1 chk("load_use_rt", 32'(dut_out), 32'(V_LOADUSE));
      cyc();
      id_uses_rt = 1'b0; id_rs = AW'(3);
      #1 chk("load_use_unused", 32'(dut_out), 32'(V_NORMAL));

      // Branch beats load-use; load-use holds a jump; jump alone flushes IF/ID
      cyc();
      id_uses_rs = 1'b1; ex_branch_taken = 1'b1;
      #1 chk("branch_over_lu", 32'(dut_out), 32'(V_BRANCH));
      cyc();
      ex_branch_taken = 1'b0; id_jump = 1'b1;
      #1 chk("lu_holds_jump", 32'(dut_out), 32'(V_LOADUSE));
      cyc();
      ex_mem_read = 1'b0;
      #1 chk("jump", 32'(dut_out), 32'(V_JUMP));

      // Memory wait of 3 cycles with a branch waiting behind it
      rst_pulse();
      mem_req = 1'b1; ex_branch_taken = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1 chk("mem_wait_freeze", 32'(dut_out), 32'(V_FREEZE));
         cyc();
      end
      mem_ready = 1'b1;
      #1 chk("mem_wait_done", 32'(dut_out), 32'(V_BRANCH));
      cyc();
      ex_branch_taken = 1'b0;
      #1 chk("mem_hit_run", 32'(dut_out), 32'(V_NORMAL));

      // Timeout after TO wait cycles, then the next access stalls afresh
      rst_pulse();
      mem_req = 1'b1;
      for (int i = 0; i < TO; i++) begin
         #1 chk("timeout_freeze", 32'(dut_out), 32'(V_FREEZE));
         cyc();
      end
      #1 chk("timeout", 32'(dut_out), 32'(V_TIMEOUT));
      cyc();
      #1 chk("timeout_restall", 32'(dut_out), 32'(V_FREEZE));

      // Asynchronous reset in the middle of a wait
      rst_pulse();
      mem_req = 1'b1;
      cyc();
      cyc();
      #2 reset = 1'b1;
      #1 chk("async_reset", 32'(dut_out), 32'(V_RESET));
      chk("async_reset_stall_cnt", stall_cycles, 32'd0);
      cyc();
      reset = 1'b0;
      for (int i = 0; i < TO; i++) begin
         #1 chk("post_reset_freeze", 32'(dut_out), 32'(V_FREEZE));
         cyc();
      end
      #1 chk("post_reset_timeout", 32'(dut_out), 32'(V_TIMEOUT));

      // Randomized traffic
      rst_pulse();
      stuck = 0;
      repeat (3000) begin
         cyc();
         reset           = ($urandom_range(0, 199) == 0);
         id_rs           = AW'($urandom_range(0, 3));
         id_rt           = AW'($urandom_range(0, 3));
         id_uses_rs      = 1'($urandom_range(0, 1));
         id_uses_rt      = 1'($urandom_range(0, 1));
         ex_mem_read     = 1'($urandom_range(0, 1));
         ex_write_reg    = AW'($urandom_range(0, 3));
         ex_branch_taken = ($urandom_range(0, 5) == 0);
         id_jump         = ($urandom_range(0, 4) == 0);
         if (stuck > 0) begin
            stuck--;
            mem_req   = 1'b1;
            mem_ready = 1'b0;
         end else begin
            if ($urandom_range(0, 15) == 0) stuck = $urandom_range(3, 8);
            mem_req   = 1'($urandom_range(0, 1));
            mem_ready = ($urandom_range(0, 2) != 0);
         end
      end

      cyc();
      cyc();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
